dct_row_buffer: RTL

- Parametrised, handshaked successor to the single-sample DCT input stage register.
- Collects a serial stream of pixel or coefficient samples into rows of N lanes and presents each completed row in parallel to the 1-D DCT datapath.
- Ping-pong double buffering lets the next row fill while the previous row waits on downstream.
- Supports early row close-out (flush) with zero padding, for partial rows at image edges.

---
 rtl/dct_row_buffer_pkg.sv | 29 ++
 rtl/dct_row_bank.sv | 50 +++++
 rtl/dct_row_buffer.sv | 102 ++++++++++
 3 files changed

// File: rtl/dct_row_buffer_pkg.sv
// Shared types and constants for the DCT input row buffer.
package dct_pkg;

  localparam int unsigned DCT_N = 8;
  localparam int unsigned PIX_W = 8;

  typedef logic [PIX_W-1:0] pix_t;
  typedef pix_t [DCT_N-1:0] row_t;

  typedef enum logic {
    BANK0 = 1'b0,
    BANK1 = 1'b1
  } bank_e;

  // Lane 0 lands in the least significant bits.
  function automatic logic [DCT_N*PIX_W-1:0] pack_row(input row_t row);
    logic [DCT_N*PIX_W-1:0] flat;
    flat = '0;
    for (int unsigned k = 0; k < DCT_N; k++) begin
      flat[k*PIX_W +: PIX_W] = row[k];
    end
    return flat;
  endfunction

  function automatic bank_e other_bank(input bank_e b);
    return (b == BANK0) ? BANK1 : BANK0;
  endfunction

endpackage

// File: rtl/dct_row_bank.sv
// One ping-pong bank: N-lane row storage, full flag and real-sample count.
module dct_row_bank
  import dct_pkg::*;
#(
  parameter int unsigned WIDTH = PIX_W,
  parameter int unsigned N     = DCT_N,
  parameter int unsigned CNT_W = $clog2(N + 1),
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en_i,
  input  logic [IDX_W-1:0]   wr_idx_i,
  input  logic [WIDTH-1:0]   wr_data_i,
  input  logic               close_i,
  input  logic [CNT_W-1:0]   close_cnt_i,
  input  logic               drain_i,
  output logic               full_o,
  output logic [CNT_W-1:0]   count_o,
  output logic [N*WIDTH-1:0] data_o
);

  logic [N-1:0][WIDTH-1:0] mem_q;
  logic                    full_q;
  logic [CNT_W-1:0]        count_q;

  // Zeroing on drain is what makes flushed rows read back zero-padded.
  always_ff @(posedge clk) begin
    if (rst || drain_i) begin
      mem_q <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || drain_i) begin
      full_q  <= 1'b0;
      count_q <= '0;
    end else if (close_i) begin
      full_q  <= 1'b1;
      count_q <= close_cnt_i;
    end
  end

  assign full_o  = full_q;
  assign count_o = count_q;
  assign data_o  = mem_q;

endmodule

// File: rtl/dct_row_buffer.sv
// Serial-to-row collector with ping-pong banks and flush-to-partial-row.
module dct_row_buffer
  import dct_pkg::*;
#(
  parameter int unsigned WIDTH = PIX_W,
  parameter int unsigned N     = DCT_N,
  parameter int unsigned CNT_W = $clog2(N + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [N*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int unsigned IDX_W = $clog2(N);

  bank_e            wr_bank_q, wr_bank_d;
  bank_e            rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] wr_cnt_q, wr_cnt_d;

  logic               full0, full1;
  logic [CNT_W-1:0]   cnt0, cnt1;
  logic [N*WIDTH-1:0] data0, data1;

  logic             wr_full, accept, last, close, drain;
  logic [CNT_W-1:0] fill;

  assign wr_full  = (wr_bank_q == BANK0) ? full0 : full1;
  assign in_ready = !rst && !wr_full;
  assign accept   = in_valid && in_ready;
  assign last     = (wr_cnt_q == IDX_W'(N - 1));
  // Fill after this cycle's sample, so a flush with a sample closes it too.
  assign fill     = CNT_W'(wr_cnt_q) + CNT_W'(accept);
  assign close    = !wr_full && ((accept && last) || (flush && (fill != '0)));

  assign out_valid = (rd_bank_q == BANK0) ? full0 : full1;
  assign out_count = (rd_bank_q == BANK0) ? cnt0  : cnt1;
  assign out_data  = (rd_bank_q == BANK0) ? data0 : data1;
  assign drain     = out_valid && out_ready;

  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_bank_d = rd_bank_q;
    if (close) begin
      wr_bank_d = other_bank(wr_bank_q);
      wr_cnt_d  = '0;
    end else if (accept) begin
      wr_cnt_d  = wr_cnt_q + IDX_W'(1);
    end
    if (drain) begin
      rd_bank_d = other_bank(rd_bank_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q <= BANK0;
      wr_cnt_q  <= '0;
      rd_bank_q <= BANK0;
    end else begin
      wr_bank_q <= wr_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  dct_row_bank #(.WIDTH(WIDTH), .N(N), .CNT_W(CNT_W), .IDX_W(IDX_W)) u_bank0 (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (accept && (wr_bank_q == BANK0)),
    .wr_idx_i    (wr_cnt_q),
    .wr_data_i   (in_data),
    .close_i     (close && (wr_bank_q == BANK0)),
    .close_cnt_i (fill),
    .drain_i     (drain && (rd_bank_q == BANK0)),
    .full_o      (full0),
    .count_o     (cnt0),
    .data_o      (data0)
  );

  dct_row_bank #(.WIDTH(WIDTH), .N(N), .CNT_W(CNT_W), .IDX_W(IDX_W)) u_bank1 (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (accept && (wr_bank_q == BANK1)),
    .wr_idx_i    (wr_cnt_q),
    .wr_data_i   (in_data),
    .close_i     (close && (wr_bank_q == BANK1)),
    .close_cnt_i (fill),
    .drain_i     (drain && (rd_bank_q == BANK1)),
    .full_o      (full1),
    .count_o     (cnt1),
    .data_o      (data1)
  );

endmodule
